compute_in_memory_array: RTL
============================

Name: compute_in_memory_array

Overview:
- Parametrised successor to the single-pair compute-in-memory cell. Holds an N x N synaptic weight matrix and a double-buffered per-neuron synaptic current array.
- Dequeues fired presynaptic tags from the spike FIFO. For each tag, adds the corresponding weight row into the working current bank.
- On swap, publishes the working bank to the neuron update stage and seeds the next timestep with decayed currents.

Parameters:
N, 4, number of neurons (pre and post); power of two, >= 2
TAG_W, 2, tag width = clog2(N)
W_W, 16, signed weight width
I_W, 17, signed current width; I_W > W_W
DECAY_SHIFT, 1, current decay: next = I - (I >>> DECAY_SHIFT); 0 gives full clear per step

Ports:
clk  in  1  clock, rising edge
asyn_reset  in  1  synchronous, active-high reset (name kept from earlier blocks)
swap  in  1  timestep-boundary pulse; latched as pending
fifo_empty  in  1  spike FIFO empty flag
req_deq  out  1  one-cycle FIFO dequeue request
fired_tag  in  TAG_W  presynaptic tag; valid the cycle after req_deq
w_we  in  1  weight write enable
w_pre  in  TAG_W  weight row (presynaptic)
w_post  in  TAG_W  weight column (postsynaptic)
w_data  in  W_W  signed weight
i_tag  in  TAG_W  front-bank read address
i_out  out  I_W  front-bank current, registered
busy  out  1  high when state != IDLE or swap pending
state_out  out  3  current state encoding

Behaviour:
- Storage:
  - weights w[pre][post], signed W_W; not cleared by reset.
  - current banks B0 and B1, signed I_W; bank_sel selects the front bank; the other bank is the work bank.
- Reset (sync):
  - state = CLR (5), bank_sel = 0, swap_pend = 0, post counter = 0.
  - Outputs: req_deq = 0, i_out = 0, busy = 1.
  - Reset overrides every state, including mid-ACCUM and mid-INIT.
- States: IDLE = 0, FETCH = 1, LATCH = 2, ACCUM = 3, INIT = 4, CLR = 5.
- CLR:
  - Writes 0 to B0[k] and B1[k] for k = 0..N-1, one k per cycle (N cycles), then goes to IDLE.
  - A swap arriving during CLR is latched.
- IDLE:
  - If fifo_empty = 0, go to FETCH. Events have priority over swap.
  - Else if swap_pend = 1, toggle bank_sel, clear swap_pend, go to INIT.
  - Else stay in IDLE.
- FETCH: req_deq = 1 for exactly this cycle; go to LATCH.
- LATCH: register fired_tag into tag_r; post counter = 0; go to ACCUM.
- ACCUM:
  - N cycles. For post = 0..N-1: work[post] = sat(work[post] + sext(w[tag_r][post])).
  - After post = N-1, go to IDLE.
  - Per-event cost: N + 3 cycles including the IDLE cycle.
- INIT:
  - N cycles. work[k] = front[k] - (front[k] >>> DECAY_SHIFT), using arithmetic shift (floor). Example: -3 with shift 1 gives -1.
  - Then go to IDLE.
- swap handling:
  - A swap pulse in any state sets swap_pend.
  - Multiple pulses before acceptance collapse into one.
  - A swap in the same cycle as its acceptance is not re-latched.
- Saturation:
  - Clamp results to [-2^(I_W-1), 2^(I_W-1)-1].
  - Example: with I_W = 17 the range is -65536..65535.
- Weight writes:
  - Accepted in any state, including during reset.
  - A same-cycle read of the same entry in ACCUM returns the old value (read-before-write).
- Read port:
  - i_out <= front[i_tag] on every clock; latency 1.
  - During CLR and the cycle after, i_out reads 0.
  - Across a swap, i_out shows the new front from the cycle after bank_sel toggles.
- busy = (state != IDLE) | swap_pend.
- state_out = state.

Test Plan:
- Reset: assert asyn_reset 1 cycle, fifo_empty = 1 → state_out = 5 and busy = 1 for 4 cycles, then state_out = 0, busy = 0. req_deq never asserts. i_out = 0 for tags 0..3.
- Single event: load w[1][0..3] = 100, 200, -50, 0; present fifo_empty = 0 for one event with tag 1 → req_deq high for 1 cycle, then LATCH, then 4 ACCUM cycles. Then pulse swap → after INIT, i_out for tags 0..3 = 100, 200, -50, 0.
- Decay: next step with no events, pulse swap → i_out = 50, 100, -25, 0. A third empty step → 25, 50, -12, 0.
- Saturation: w[0][0] = 32767, three tag-0 events → front[0] = 65535. w[0][1] = -32768, three tag-0 events → front[1] = -65536.
- Swap deferral: pulse swap while fifo_empty = 0 with 2 queued events → both events are processed before INIT is entered. busy stays 1 throughout. Resulting i_out includes both events.
- Reset mid-ACCUM: assert asyn_reset at ACCUM post = 2 → state goes to CLR next cycle and req_deq = 0. Afterwards both banks read 0 after two swaps. Weights are unchanged, verified by re-running the single-event case.

Source files
------------

// File: rtl/compute_in_memory_array_if.sv
// +----------------------------------------------------------------------------+
// | compute_in_memory_array_if : spike/weight/readout bus of the CIM array     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface compute_in_memory_array_if #(
    parameter int TAG_W = 2,
    parameter int W_W   = 16,
    parameter int I_W   = 17
);
    logic                    swap;
    logic                    fifo_empty;
    logic                    req_deq;
    logic        [TAG_W-1:0] fired_tag;
    logic                    w_we;
    logic        [TAG_W-1:0] w_pre;
    logic        [TAG_W-1:0] w_post;
    logic signed [W_W-1:0]   w_data;
    logic        [TAG_W-1:0] i_tag;
    logic signed [I_W-1:0]   i_out;
    logic                    busy;
    logic        [2:0]       state_out;

    modport master (
        output swap, fifo_empty, fired_tag, w_we, w_pre, w_post, w_data, i_tag,
        input  req_deq, i_out, busy, state_out
    );

    modport slave (
        input  swap, fifo_empty, fired_tag, w_we, w_pre, w_post, w_data, i_tag,
        output req_deq, i_out, busy, state_out
    );
endinterface

`default_nettype wire

// File: rtl/compute_in_memory_array.sv
// +----------------------------------------------------------------------------+
// | compute_in_memory_array : NxN weight matrix with double-buffered currents  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module compute_in_memory_array #(
    parameter int N           = 4,
    parameter int TAG_W       = 2,
    parameter int W_W         = 16,
    parameter int I_W         = 17,
    parameter int DECAY_SHIFT = 1
) (
    input  wire logic                 clk,
    input  wire logic                 asyn_reset,
    compute_in_memory_array_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        ACCUM = 3'd3,
        INIT  = 3'd4,
        CLR   = 3'd5
    } state_t;

    state_t                  state_q;
    logic                    bank_sel_q;
    logic                    swap_pend_q;
    logic                    req_deq_q;
    logic        [TAG_W-1:0] cnt_q;
    logic        [TAG_W-1:0] tag_q;
    logic signed [I_W-1:0]   i_out_q;

    logic signed [W_W-1:0]   w_q    [N][N];
    logic signed [I_W-1:0]   bank_q [2][N];

    logic signed [W_W-1:0]   wt_d;
    logic signed [I_W-1:0]   work_d;
    logic signed [I_W-1:0]   front_d;
    logic        [I_W:0]     sum_d;
    logic signed [I_W-1:0]   acc_d;
    logic signed [I_W-1:0]   dec_d;
    logic                    last_d;

    always_ff @(posedge clk) begin
        if (bus.w_we) begin
            w_q[bus.w_pre][bus.w_post] <= bus.w_data;
        end
    end

    always_comb begin
        wt_d    = w_q[tag_q][cnt_q];
        work_d  = bank_q[~bank_sel_q][cnt_q];
        front_d = bank_q[bank_sel_q][cnt_q];
        sum_d   = {work_d[I_W-1], work_d} + {{(I_W+1-W_W){wt_d[W_W-1]}}, wt_d};
        // One extra bit of headroom: differing top bits mean the sum left the I_W range.
        if (sum_d[I_W] != sum_d[I_W-1]) begin
            acc_d = sum_d[I_W] ? {1'b1, {(I_W-1){1'b0}}} : {1'b0, {(I_W-1){1'b1}}};
        end else begin
            acc_d = sum_d[I_W-1:0];
        end
        dec_d  = front_d - (front_d >>> DECAY_SHIFT);
        last_d = (cnt_q == TAG_W'(N-1));
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q     <= CLR;
            bank_sel_q  <= 1'b0;
            swap_pend_q <= 1'b0;
            cnt_q       <= '0;
            req_deq_q   <= 1'b0;
            i_out_q     <= '0;
        end else begin
            req_deq_q <= 1'b0;
            i_out_q   <= (state_q == CLR) ? '0 : bank_q[bank_sel_q][bus.i_tag];
            if (bus.swap) begin
                swap_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!bus.fifo_empty) begin
                        state_q   <= FETCH;
                        req_deq_q <= 1'b1;
                    end else if (swap_pend_q) begin
                        // Acceptance wins over a coincident pulse, so it is not re-latched.
                        bank_sel_q  <= ~bank_sel_q;
                        swap_pend_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= INIT;
                    end
                end
                FETCH: state_q <= LATCH;
                LATCH: begin
                    tag_q   <= bus.fired_tag;
                    cnt_q   <= '0;
                    state_q <= ACCUM;
                end
                ACCUM: begin
                    bank_q[~bank_sel_q][cnt_q] <= acc_d;
                    cnt_q <= cnt_q + TAG_W'(1);
                    if (last_d) state_q <= IDLE;
                end
                INIT: begin
                    bank_q[~bank_sel_q][cnt_q] <= dec_d;
                    cnt_q <= cnt_q + TAG_W'(1);
                    if (last_d) state_q <= IDLE;
                end
                CLR: begin
                    bank_q[0][cnt_q] <= '0;
                    bank_q[1][cnt_q] <= '0;
                    cnt_q <= cnt_q + TAG_W'(1);
                    if (last_d) state_q <= IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= CLR;
                end
            endcase
        end
    end

    assign bus.req_deq   = req_deq_q;
    assign bus.i_out     = i_out_q;
    assign bus.busy      = (state_q != IDLE) | swap_pend_q;
    assign bus.state_out = state_q;

endmodule

`default_nettype wire
